// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_pkg
// Description : Shared FSM state encoding and instruction opcode layout.
// Revision    : 1.0
// ============================================================================
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_HALT  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    localparam logic [2:0] HALT_OPCODE = 3'b111;
    localparam int         OPC_HI      = 15;
    localparam int         OPC_LO      = 13;

    function automatic logic is_halt(input logic [15:0] word);
        return word[OPC_HI:OPC_LO] == HALT_OPCODE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_prog_mem.sv
`default_nettype none
// ============================================================================
// Module      : prog_mem
// Description : DEPTH x WIDTH program store, one write port, one registered read.
// Revision    : 1.0
// ============================================================================
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset so a program survives resetn.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetches instructions from program memory and hands them to a
//               processor one at a time, with halt detection and a watchdog.
// Revision    : 1.0
// ============================================================================
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [WIDTH-1:0]         load_data,
    input  logic                     start,
    input  logic                     proc_done,
    output logic [WIDTH-1:0]         iin,
    output logic                     run,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic                     busy,
    output logic                     halted,
    output logic                     error
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WDW = $clog2(TIMEOUT + 1);

    state_t           state_q;
    logic [AW-1:0]    pc_q;
    logic [AW-1:0]    pc_d;
    logic [WIDTH-1:0] iin_q;
    logic             run_q;
    logic             busy_q;
    logic             halted_q;
    logic             error_q;
    logic [WDW-1:0]   wdog_q;
    logic [WIDTH-1:0] mem_rdata;
    logic             idle_like;
    logic             load_ok;
    logic             start_ok;
    logic             last_pc;

    always_comb begin
        idle_like = state_q inside {S_IDLE, S_HALT, S_ERROR};
        load_ok   = idle_like && load_en;
        start_ok  = idle_like && start && !load_en;
        last_pc   = pc_q == AW'(DEPTH - 1);
        pc_d      = pc_q;
        if (start_ok) begin
            pc_d = '0;
        end else if (state_q == S_WAIT && proc_done && !last_pc) begin
            pc_d = pc_q + 1'b1;
        end
    end

    // The memory is addressed with the next pc so the word is ready in FETCH.
    prog_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_prog_mem (
        .clock   (clock),
        .we_i    (load_ok),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .raddr_i (pc_d),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            iin_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            error_q  <= 1'b0;
            wdog_q   <= '0;
        end else begin
            pc_q  <= pc_d;
            run_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (start_ok) begin
                        state_q  <= S_FETCH;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                        error_q  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    iin_q <= mem_rdata;
                    if (is_halt(mem_rdata)) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_ISSUE;
                        run_q   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    wdog_q  <= '0;
                end
                S_WAIT: begin
                    // A completion on the final watchdog cycle still wins.
                    if (proc_done) begin
                        if (last_pc) begin
                            state_q  <= S_HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                        if (wdog_q == WDW'(TIMEOUT - 1)) begin
                            state_q <= S_ERROR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign iin    = iin_q;
    assign run    = run_q;
    assign pc     = pc_q;
    assign busy   = busy_q;
    assign halted = halted_q;
    assign error  = error_q;

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: DEPTH, 16, number of program memory words (power of two).
REQ-002 Parameter: WIDTH, 16, instruction width in bits.
REQ-003 Parameter: TIMEOUT, 32, maximum WAIT cycles before error.
REQ-004 Port: clock  in  1  single system clock; all logic rising-edge.
REQ-005 Port: resetn  in  1  synchronous, active-low reset.
REQ-006 Port: load_en  in  1  write load_data into program memory at load_addr.
REQ-007 Port: load_addr  in  log2(DEPTH)  program memory write address.
REQ-008 Port: load_data  in  WIDTH  instruction word to store.
REQ-009 Port: start  in  1  begin execution at address 0.
REQ-010 Port: proc_done  in  1  processor finished current instruction.
REQ-011 Port: iin  out  WIDTH  instruction presented to the processor.
REQ-012 Port: run  out  1  one-cycle pulse: processor shall latch iin.
REQ-013 Port: pc  out  log2(DEPTH)  address of current instruction.
REQ-014 Port: busy  out  1  high in FETCH, ISSUE, WAIT.
REQ-015 Port: halted  out  1  high in HALT.
REQ-016 Port: error  out  1  high in ERROR.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, ISSUE, WAIT, HALT, ERROR.
REQ-018 load_en SHALL write memory only in IDLE, HALT or ERROR; ignored otherwise.
REQ-019 Written word SHALL be readable by FETCH on the cycle after the write.
REQ-020 start in IDLE/HALT/ERROR SHALL clear pc to 0, clear halted/error, enter FETCH next cycle.
REQ-021 load_en and start asserted together: load SHALL complete, start SHALL be ignored that cycle.
REQ-022 start while busy SHALL be ignored.
REQ-023 FETCH: iin SHALL register mem[pc]; if mem[pc][15:13] == HALT opcode 3'b111, next state HALT, else ISSUE.
REQ-024 ISSUE: run SHALL be 1 for exactly this cycle; next state WAIT; iin stable from FETCH until WAIT exits.
REQ-025 WAIT: proc_done SHALL be sampled only here; proc_done during ISSUE SHALL be ignored.
REQ-026 WAIT with proc_done=1 and pc < DEPTH-1: pc increments by 1, next state FETCH.
REQ-027 WAIT with proc_done=1 and pc == DEPTH-1: pc holds, next state HALT (no wrap).
REQ-028 Watchdog counter SHALL clear on entry to WAIT and count each WAIT cycle without proc_done.
REQ-029 Watchdog reaching TIMEOUT SHALL force ERROR next cycle; proc_done on that same cycle SHALL take precedence (normal advance).
REQ-030 Instruction latency: run SHALL rise 2 cycles after start or after accepted proc_done.
REQ-031 HALT and ERROR: run=0, iin holds last fetched word, pc holds.

Reset
REQ-032 resetn=0 at a rising edge SHALL force IDLE, pc=0, iin=0, run=0, busy=0, halted=0, error=0, watchdog=0.
REQ-033 Reset mid-execution SHALL abort immediately; no run pulse in the cycle after reset.
REQ-034 Program memory contents SHALL NOT be reset; a reload is not required after reset.

Structure
REQ-035 Shared package SHALL hold the state enum, HALT opcode 3'b111, opcode field position [15:13].
REQ-036 Program memory SHALL be a sub-module prog_mem (DEPTH x WIDTH, one write port, one sync read).
REQ-037 FSM, pc and watchdog SHALL reside in instr_sequencer.

Verification
REQ-038 Load A00A, A405, 0840, 8800, E000 at 0..4; start; proc_done 3 cycles after each run -> iin sequence A00A, A405, 0840, 8800, four run pulses, halted=1 with pc=4.
REQ-039 All 16 words 0x0840, done after each run -> 16 run pulses, halted=1, pc=15, no wrap to 0.
REQ-040 Word 0 = A00A, proc_done withheld -> error=1 after 32 WAIT cycles, run stays 0; start -> error=0, re-fetch A00A.
REQ-041 resetn=0 during WAIT at pc=2 -> next cycle IDLE, pc=0, iin=0, busy=0; memory word 2 unchanged.
REQ-042 load_en+start same cycle in IDLE (addr 0, data E000) -> word written, state stays IDLE; later start -> halted=1, no run.
REQ-043 load_en while busy (addr 1, data FFFF) -> memory word 1 unchanged, execution unaffected.
